sort_avalon_pipe: RTL

// Avalon-ST packet sorter, next generation of the single-mode sorter: buffers one packet of up to
// MAX_PKT_LEN words, sorts it ascending or descending (mode chosen per packet) by insertion on

---
 rtl/sort_avalon_pkg.sv | 7 +
 rtl/sort_insert_array.sv | 35 +++
 rtl/sort_avalon_pipe.sv | 74 +++++++
 3 files changed

// File: rtl/sort_avalon_pkg.sv
// sort_avalon_pkg: shared FSM state type and counter-width helper for the packet sorter
package sort_avalon_pkg;
  typedef enum logic {RECV, SEND} sort_state_t;
  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/sort_insert_array.sv
// sort_insert_array: sorted register array with single-cycle parallel-compare insertion
module sort_insert_array import sort_avalon_pkg::*; #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16,
  localparam int CW = cnt_w(MAX_PKT_LEN),
  localparam int IW = $clog2(MAX_PKT_LEN)
) (
  input  logic              clk_i,
  input  logic              ins_i,
  input  logic              clr_i,
  input  logic              desc_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic [CW-1:0]     count_i,
  input  logic [IW-1:0]     rd_idx_i,
  output logic [DWIDTH-1:0] rd_data_o
);
  logic [DWIDTH-1:0]      r_a [MAX_PKT_LEN];
  logic [DWIDTH-1:0]      w_nxt [MAX_PKT_LEN];
  logic [MAX_PKT_LEN-1:0] w_after, w_pos;
  logic [CW-1:0]          w_cnt;
  assign w_cnt = clr_i ? '0 : count_i;
  // w_after is a thermometer over the sorted contents; empty slots count as "after"
  for (genvar i = 0; i < MAX_PKT_LEN; i++) begin : g_slot
    assign w_after[i] = (CW'(i) < w_cnt) ? (desc_i ? data_i > r_a[i] : data_i < r_a[i]) : 1'b1;
    if (i == 0) begin : g_first
      assign w_nxt[i] = w_pos[i] ? data_i : r_a[i];
    end else begin : g_rest
      assign w_nxt[i] = w_pos[i] ? data_i : w_after[i] ? r_a[i-1] : r_a[i];
    end
  end
  assign w_pos = w_after & ~(w_after << 1);
  always_ff @(posedge clk_i)
    if (ins_i) r_a <= w_nxt;
  assign rd_data_o = r_a[rd_idx_i];
endmodule

// File: rtl/sort_avalon_pipe.sv
// sort_avalon_pipe: Avalon-ST packet sorter, per-packet ascending/descending, truncates oversize packets
module sort_avalon_pipe import sort_avalon_pkg::*; #(
  parameter int DWIDTH      = 8,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              mode_desc_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_valid_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_error_o,
  input  logic              src_ready_i
);
  localparam int CW = cnt_w(MAX_PKT_LEN);
  localparam int IW = $clog2(MAX_PKT_LEN);
  sort_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_count, r_rd_ptr;
  logic          r_in_pkt, r_ovf, r_mode;
  logic          w_acc, w_sop, w_take, w_full, w_ins, w_end, w_last, w_pop;
  assign w_acc  = snk_valid_i & snk_ready_o;
  assign w_sop  = w_acc & snk_startofpacket_i;
  assign w_take = w_acc & (snk_startofpacket_i | r_in_pkt);
  assign w_full = r_count == CW'(MAX_PKT_LEN);
  assign w_ins  = w_sop | (w_take & ~w_full);
  assign w_end  = w_take & snk_endofpacket_i;
  assign w_last = r_rd_ptr == r_count - 1'b1;
  assign w_pop  = src_valid_o & src_ready_i;
  assign snk_ready_o         = r_state == RECV;
  assign src_valid_o         = r_state == SEND;
  assign src_startofpacket_o = src_valid_o & (r_rd_ptr == '0);
  assign src_endofpacket_o   = src_valid_o & w_last;
  assign src_error_o         = src_endofpacket_o & r_ovf;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = r_state == RECV ? (w_end ? SEND : RECV) : (w_pop & w_last ? RECV : SEND);
  end
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      r_state  <= RECV;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_in_pkt <= 1'b0;
      r_ovf    <= 1'b0;
      r_mode   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sop) begin
        r_count <= CW'(1);
        r_mode  <= mode_desc_i;
        r_ovf   <= 1'b0;
      end else if (w_ins) r_count <= r_count + 1'b1;
      else if (w_take) r_ovf <= 1'b1;
      if (w_end) r_in_pkt <= 1'b0;
      else if (w_sop) r_in_pkt <= 1'b1;
      if (w_pop) r_rd_ptr <= w_last ? '0 : r_rd_ptr + 1'b1;
    end
  sort_insert_array #(.DWIDTH(DWIDTH), .MAX_PKT_LEN(MAX_PKT_LEN)) u_arr (
    .clk_i    (clk_i),
    .ins_i    (w_ins),
    .clr_i    (w_sop),
    .desc_i   (w_sop ? mode_desc_i : r_mode),
    .data_i   (snk_data_i),
    .count_i  (r_count),
    .rd_idx_i (r_rd_ptr[IW-1:0]),
    .rd_data_o(src_data_o)
  );
endmodule
